// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial unified RAM controller.
package mem_ctrl_pkg;
   localparam int unsigned AddrWidth  = 32;
   localparam int unsigned DataWidth  = 32;
   localparam int unsigned RamLatency = 1;
   localparam int unsigned CntWidth   = 3;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
   typedef enum logic [1:0] {LenByte = 2'b00, LenHalf = 2'b01, LenWord = 2'b10} len_e;
   typedef enum logic {OwnIF = 1'b0, OwnMEM = 1'b1} owner_e;

   // Reserved code 11 behaves as a word access.
   function automatic len_e len_decode(input logic [1:0] code);
      case (code)
         2'b00:   return LenByte;
         2'b01:   return LenHalf;
         default: return LenWord;
      endcase
   endfunction

   function automatic logic [CntWidth-1:0] len_bytes(input len_e len);
      case (len)
         LenByte: return CntWidth'(1);
         LenHalf: return CntWidth'(2);
         default: return CntWidth'(4);
      endcase
   endfunction
endpackage

// File: rtl/mem_ctrl_byte_pack.sv
// Combines four little-endian bytes into a 32-bit load result with sign/zero extension.
module mem_byte_pack
   import mem_ctrl_pkg::*;
(
   input  logic [3:0][7:0]       i_bytes,
   input  len_e                  i_len,
   input  logic                  i_signed,
   output logic [DataWidth-1:0]  o_data_c
);
   always_comb begin
      o_data_c = i_bytes;
      case (i_len)
         LenByte: o_data_c = {{24{i_signed & i_bytes[0][7]}}, i_bytes[0]};
         LenHalf: o_data_c = {{16{i_signed & i_bytes[1][7]}}, i_bytes[1], i_bytes[0]};
         default: o_data_c = i_bytes;
      endcase
   end
endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM onto a byte-wide RAM, sequencing each access as 1/2/4 byte cycles.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  if_req,
   input  logic [AddrWidth-1:0]  if_addr,
   output logic [DataWidth-1:0]  if_data,
   output logic                  if_done,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  mem_signed,
   input  logic [AddrWidth-1:0]  mem_addr,
   input  logic [1:0]            mem_len,
   input  logic [DataWidth-1:0]  mem_w_data,
   output logic [DataWidth-1:0]  mem_r_data,
   output logic                  mem_done,
   output logic [AddrWidth-1:0]  ram_addr,
   output logic                  ram_wr,
   output logic [7:0]            ram_dout,
   input  logic [7:0]            ram_din
);
   state_e                r_state;
   owner_e                r_owner;
   len_e                  r_len;
   logic                  r_write;
   logic                  r_signed;
   logic [23:0]           r_wdata;
   logic [CntWidth-1:0]   r_cnt;
   logic [3:0][7:0]       r_asm;
   logic [AddrWidth-1:0]  r_ram_addr;
   logic                  r_ram_wr;
   logic [7:0]            r_ram_dout;
   logic [DataWidth-1:0]  r_if_data;
   logic                  r_if_done;
   logic [DataWidth-1:0]  r_mem_r_data;
   logic                  r_mem_done;

   logic [CntWidth-1:0]   w_n;
   logic [CntWidth-1:0]   w_last_rd;
   logic [1:0]            w_idx;
   logic [3:0][7:0]       w_asm;
   logic [DataWidth-1:0]  w_pack;

   assign w_n       = len_bytes(r_len);
   assign w_last_rd = w_n + CntWidth'(RamLatency - 1);
   assign w_idx     = 2'(r_cnt - CntWidth'(RamLatency));

   // Merge the byte arriving this cycle so the final byte is included on the DONE transition.
   always_comb begin
      w_asm = r_asm;
      if (r_cnt >= CntWidth'(RamLatency)) w_asm[w_idx] = ram_din;
   end

   mem_byte_pack u_pack (
      .i_bytes  (w_asm),
      .i_len    (r_len),
      .i_signed (r_signed),
      .o_data_c (w_pack)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state      <= IDLE;
         r_owner      <= OwnIF;
         r_len        <= LenWord;
         r_write      <= 1'b0;
         r_signed     <= 1'b0;
         r_wdata      <= '0;
         r_cnt        <= '0;
         r_asm        <= '0;
         r_ram_addr   <= '0;
         r_ram_wr     <= 1'b0;
         r_ram_dout   <= '0;
         r_if_data    <= '0;
         r_if_done    <= 1'b0;
         r_mem_r_data <= '0;
         r_mem_done   <= 1'b0;
      end else begin
         r_if_done  <= 1'b0;
         r_mem_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               r_asm <= '0;
               if (mem_read || mem_write) begin
                  r_state    <= BUSY;
                  r_owner    <= OwnMEM;
                  r_len      <= len_decode(mem_len);
                  r_write    <= mem_write;
                  r_signed   <= mem_signed;
                  r_wdata    <= mem_w_data[31:8];
                  r_ram_addr <= mem_addr;
                  r_ram_wr   <= mem_write;
                  r_ram_dout <= mem_write ? mem_w_data[7:0] : 8'h00;
               end else if (if_req) begin
                  r_state    <= BUSY;
                  r_owner    <= OwnIF;
                  r_len      <= LenWord;
                  r_write    <= 1'b0;
                  r_signed   <= 1'b0;
                  r_wdata    <= '0;
                  r_ram_addr <= if_addr;
                  r_ram_wr   <= 1'b0;
                  r_ram_dout <= 8'h00;
               end
            end
            BUSY: begin
               if (r_write) begin
                  if (r_cnt == w_n - CntWidth'(1)) begin
                     r_state    <= DONE;
                     r_ram_wr   <= 1'b0;
                     r_ram_dout <= 8'h00;
                     r_mem_done <= (r_owner == OwnMEM);
                     r_if_done  <= (r_owner == OwnIF);
                  end else begin
                     r_cnt      <= r_cnt + CntWidth'(1);
                     r_ram_addr <= r_ram_addr + AddrWidth'(1);
                     r_ram_dout <= r_wdata[7:0];
                     r_wdata    <= {8'h00, r_wdata[23:8]};
                  end
               end else begin
                  r_asm <= w_asm;
                  if (r_cnt == w_last_rd) begin
                     r_state <= DONE;
                     if (r_owner == OwnIF) begin
                        r_if_data <= w_pack;
                        r_if_done <= 1'b1;
                     end else begin
                        r_mem_r_data <= w_pack;
                        r_mem_done   <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + CntWidth'(1);
                     if (r_cnt + CntWidth'(1) < w_n) r_ram_addr <= r_ram_addr + AddrWidth'(1);
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_data    = r_if_data;
   assign if_done    = r_if_done;
   assign mem_r_data = r_mem_r_data;
   assign mem_done   = r_mem_done;
   assign ram_addr   = r_ram_addr;
   assign ram_wr     = r_ram_wr;
   assign ram_dout   = r_ram_dout;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Sequencing controller and arbiter for the single byte-wide unified RAM. Shares that RAM between instruction fetch (IF) and the MEM stage. Each 32-bit access is split into 1, 2 or 4 byte-serial RAM cycles, read bytes are reassembled with sign or zero extension, and the requester gets a one-cycle done pulse. Sits between the pipeline stages and the RAM macro.

## Interface
- No parameters. The address/data widths (32) and RAM read latency (1) are package constants.
- clk_in  in  1  system clock, all state on rising edge
- rst_in  in  1  asynchronous, active-high reset
- if_req  in  1  IF requests a 4-byte unsigned read
- if_addr  in  32  IF byte address
- if_data  out  32  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse to IF
- mem_read / mem_write  in  1 / 1  MEM stage load / store request
- mem_signed  in  1  sign-extend the load result
- mem_addr  in  32  MEM byte address
- mem_len  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_w_data  in  32  store data; low bytes used
- mem_r_data  out  32  extended load result, valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse to MEM
- ram_addr  out  32  RAM byte address
- ram_wr  out  1  1 = write ram_dout this cycle
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid the cycle after its address

## Operation
- Arbitration is evaluated only in IDLE. MEM has priority over IF. A granted access is never pre-empted.
- If mem_read and mem_write are both high, the write wins.
- On grant, the controller latches the owner, address, length N (1/2/4), direction, signed flag and write data. Counter cnt=0. Go to BUSY.
- BUSY, write: ram_addr=base+cnt, ram_wr=1, ram_dout=wdata[8*cnt+7:8*cnt]. Runs cnt=0..N-1, then DONE.
- BUSY, read: while cnt<N, ram_addr=base+cnt and ram_wr=0. When cnt≥1, ram_din is captured into byte cnt-1. Runs cnt=0..N, then DONE.
- Bytes are little-endian: byte k of the access goes to bits [8k+7:8k].
- DONE: the owner's done pulse is high and its result is stable. Always returns to IDLE next cycle; no grant is made in DONE.
- Extension of the read result:
  - byte or half with mem_signed=1: sign-extend from bit 7 or bit 15.
  - otherwise: zero-extend.
- Address arithmetic wraps modulo 2^32 with no carry flag.
- Requesters hold their request until they see done, and drop or change it at the edge ending the done cycle. A request still held in DONE is not re-served.
- Reset values of all outputs: ram_addr=0, ram_wr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_r_data=0. State=IDLE, cnt=0.
- Reset mid-access aborts immediately. Bytes already written stay in RAM (no rollback). No done pulse is issued.

## Timing
- Count cycles from cycle 0, the IDLE cycle in which the request is first sampled high.
- Read: BUSY for cycles 1..N+1, done in cycle N+2. Byte read done in cycle 3, half in 4, word in 6.
- Write: BUSY for cycles 1..N, done in cycle N+1. Byte write done in cycle 2, word in 5.
- A new request can be sampled no earlier than the cycle after DONE, so back-to-back word reads complete every 7 cycles.
- ram_wr is never high outside BUSY-write cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from request inputs to ram_*.

## Structure
- Shared package holds:
  - state encoding IDLE/BUSY/DONE
  - length codes LenByte/LenHalf/LenWord
  - owner codes OwnIF/OwnMEM
  - AddrWidth=32, DataWidth=32, RamLatency=1
- Natural sub-module mem_byte_pack: a combinational block taking the 4 assembled bytes, length and signed flag, and returning the extended 32-bit result. It is reused by the load path elsewhere.

## Test plan
- IF only: if_req=1, if_addr=0x100, RAM[0x100..0x103]=0x13,0x05,0x00,0x00. Required: ram_addr 0x100..0x103 in cycles 1–4, if_done in cycle 6, if_data=0x00000513.
- Signed byte load: mem_read=1, len=00, signed=1, addr=0x20, RAM[0x20]=0x80. Required: mem_done in cycle 3, mem_r_data=0xFFFFFF80. Repeat with signed=0: 0x00000080.
- Half store: mem_write=1, len=01, addr=0x40, data=0xDEADBEEF. Required: ram_wr with 0xEF @0x40 in cycle 1 and 0xBE @0x41 in cycle 2, mem_done in cycle 3, RAM[0x42] untouched.
- Simultaneous: if_req and mem_read both high in the same IDLE cycle. Required: MEM is served first; IF's first ram_addr appears in the cycle after mem_done + 1, and if_done follows 6 cycles after that sampling.
- Address wrap: word read at 0xFFFFFFFE. Required: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in order.
- Reset mid-write: assert rst_in during cycle 2 of a word store. Required: ram_wr=0 immediately and no done pulse; only bytes 0–1 are written. A fresh request after reset completes normally.
